// File: rtl/fmdll_pkg.sv
// Shared constants and types for the fmdll divider path.
// FDN_PERIOD_CNT_EN enables the period counter on fd_n_counter.
package fmdll_pkg;
   localparam int N_W = 4;
   typedef logic [N_W-1:0] n_t;
   localparam n_t MIN_N = n_t'(2);
   localparam n_t DEFAULT_N = n_t'(8);
   localparam logic [7:0] PCNT_MAX = 8'hFF;

   function automatic n_t clamp_n(input n_t n);
      return (n < MIN_N) ? MIN_N : n;
   endfunction
endpackage

// File: rtl/fd_n_counter_if.sv
// Control/status bundle between the DLL control block and fd_n_counter.
// FDN_PERIOD_CNT_EN adds period_cnt to the bundle.
interface fd_n_counter_if;
   import fmdll_pkg::*;

   logic en;
   n_t   N_in;
   logic N_load;
   n_t   N_counter;
   n_t   N_active;
   logic wrap;
   logic n_pending;
`ifdef FDN_PERIOD_CNT_EN
   logic [7:0] period_cnt;

   modport master (
      output en, N_in, N_load,
      input  N_counter, N_active, wrap, n_pending, period_cnt
   );
   modport slave (
      input  en, N_in, N_load,
      output N_counter, N_active, wrap, n_pending, period_cnt
   );
`else
   modport master (
      output en, N_in, N_load,
      input  N_counter, N_active, wrap, n_pending
   );
   modport slave (
      input  en, N_in, N_load,
      output N_counter, N_active, wrap, n_pending
   );
`endif
endinterface

// File: rtl/fd_n_shadow.sv
// Shadow register for the divide ratio: clamp, pending flag, apply strobe.
// Unaffected by FDN_PERIOD_CNT_EN.
module fd_n_shadow
   import fmdll_pkg::*;
(
   input  logic clk_out,
   input  logic rst,
   input  n_t   N_in,
   input  logic N_load,
   input  logic boundary,
   output n_t   shadow,
   output logic n_pending,
   output logic apply
);

   // A load on a boundary edge wins: the new value waits for the next one.
   assign apply = boundary & n_pending & ~N_load;

   always_ff @(posedge clk_out or posedge rst) begin
      if (rst) begin
         shadow    <= DEFAULT_N;
         n_pending <= 1'b0;
      end else if (N_load) begin
         shadow    <= clamp_n(N_in);
         n_pending <= 1'b1;
      end else if (apply) begin
         n_pending <= 1'b0;
      end
   end

endmodule

// File: rtl/fd_n_counter.sv
// Modulo-N phase counter feeding the N-divider, with boundary-shadowed N.
// FDN_PERIOD_CNT_EN adds a saturating boundary counter (period_cnt).
module fd_n_counter
   import fmdll_pkg::*;
(
   input  logic           clk_out,
   input  logic           rst,
   fd_n_counter_if.slave  bus
);

   n_t   cnt_q;
   n_t   act_q;
   n_t   shadow;
   logic boundary;
   logic apply;
   logic pending;

   // >= rather than == lets an out-of-range count recover in one edge.
   assign boundary = bus.en & (cnt_q >= act_q);

   fd_n_shadow u_shadow (
      .clk_out  (clk_out),
      .rst      (rst),
      .N_in     (bus.N_in),
      .N_load   (bus.N_load),
      .boundary (boundary),
      .shadow   (shadow),
      .n_pending(pending),
      .apply    (apply)
   );

   always_ff @(posedge clk_out or posedge rst) begin
      if (rst) begin
         cnt_q <= n_t'(1);
      end else if (bus.en) begin
         cnt_q <= boundary ? n_t'(1) : cnt_q + n_t'(1);
      end
   end

   always_ff @(posedge clk_out or posedge rst) begin
      if (rst) begin
         act_q <= DEFAULT_N;
      end else if (apply) begin
         act_q <= shadow;
      end
   end

   assign bus.N_counter = cnt_q;
   assign bus.N_active  = act_q;
   assign bus.wrap      = (cnt_q == act_q);
   assign bus.n_pending = pending;

`ifdef FDN_PERIOD_CNT_EN
   logic [7:0] pcnt_q;

   always_ff @(posedge clk_out or posedge rst) begin
      if (rst) begin
         pcnt_q <= 8'd0;
      end else if (apply) begin
         pcnt_q <= 8'd0;
      end else if (boundary && pcnt_q != PCNT_MAX) begin
         pcnt_q <= pcnt_q + 8'd1;
      end
   end

   assign bus.period_cnt = pcnt_q;
`endif

endmodule
